inst_mem_resp: RTL and testbench
================================

Name: inst_mem_resp

Overview:
- Instruction-memory responder: the far end of the fetch interface driven by the program counter.
- Accepts a byte address and chip-enable from the PC each cycle. Returns the 32-bit instruction word after a fixed, parameterised latency, with a valid/ready handshake towards the decode stage.
- Provides a word-wide loader write port so a testbench or boot block can fill the memory before execution.
- Flags misaligned and out-of-range fetches instead of returning garbage.

Parameters:
- DEPTH, 256, number of 32-bit words stored. The byte range is 0 to 4*DEPTH-1, so the default matches the PC chip-enable window of 0x000 to 0x3FF.
- LATENCY, 1, cycles from request acceptance to response valid. Legal values are 1 to 4; elaboration fails outside this range.
- AW, 8, word-address width, equal to clog2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_ce  in  1  fetch request valid, driven by the PC
- inst_addr  in  32  fetch byte address
- req_ready  out  1  responder can accept a request this cycle
- inst  out  32  instruction word
- inst_valid  out  1  inst, inst_err and inst_pc are valid
- inst_err  out  1  response is for a misaligned or out-of-range address
- inst_pc  out  32  byte address of the request that produced this response
- resp_ready  in  1  decode stage accepts the response
- ld_we  in  1  loader write enable
- ld_addr  in  AW  loader word address
- ld_data  in  32  loader write data

Behaviour:
- Reset: pipeline valid bits, inst_valid and inst_err are 0; inst and inst_pc are 0; req_ready is 1. Memory contents are not reset.
- Reset asserted mid-operation clears all in-flight requests on the same edge. No response is ever produced for a request accepted before reset.
- Handshakes:
  - A request is accepted on an edge where inst_ce=1 and req_ready=1.
  - A response is consumed on an edge where inst_valid=1 and resp_ready=1.
- Stall: stall = inst_valid and not resp_ready. req_ready = not stall, computed combinationally.
  - During a stall the whole pipeline freezes.
  - inst, inst_err, inst_pc and inst_valid hold their values.
  - Requests are not accepted.
- Pipeline: LATENCY stages, each holding valid, pc, err and data. Stage 1 captures on acceptance. Data is read from the memory array at accept time (synchronous read), and each later stage shifts one stage per non-stalled cycle.
  - The last stage drives the outputs.
  - Throughput is one response per cycle when resp_ready stays at 1.
  - Acceptance at edge N gives inst_valid=1 after edge N+LATENCY-1 with no stall. For LATENCY=1 this means valid right after the accept edge.
- Bubbles: if inst_ce=0 on a non-stalled edge, stage 1 loads valid=0. Bubbles propagate, and inst_valid is 0 when a bubble reaches the output.
- Error detection:
  - err=1 if inst_addr[1:0]!=0, or if inst_addr[31:2] is at or above DEPTH.
  - When err=1, data is forced to 0x00000000 and the memory is not indexed.
  - A correct address at index DEPTH-1 returns the stored word with err=0.
- Indexing: word index = inst_addr[AW+1:2], with the upper bits checked for the range condition.
- Loader: on an edge with ld_we=1, mem[ld_addr] is updated regardless of stall.
  - If the loader and a fetch hit the same word on the same edge, the fetch returns the old data (read-before-write).
  - The loader has no ready signal and is always accepted.
- Wrap-around is not performed. Addresses at or above 4*DEPTH are errors, never aliases.

Decomposition:
- Shared package (cpu_pkg): word width constant (32), the instruction-fetch response struct {valid, err, pc[31:0], data[31:0]}, and the NOP encoding constant (0x00000000) used as the error fill.
- One natural sub-module: inst_mem_array. It holds the single-port synchronous-read, synchronous-write word memory, parameterised by DEPTH, with read-before-write on collision.
- The pipeline, error checks and handshake stay in inst_mem_resp.

Test Plan:
- Load mem[0..3] = 0x11,0x22,0x33,0x44 and fetch 0x0,0x4,0x8,0xC back-to-back with resp_ready=1 and LATENCY=2 -> inst_valid rises after the 2nd edge; inst = 0x11,0x22,0x33,0x44 on consecutive cycles; inst_pc matches each address; inst_err=0.
- Same stream with resp_ready=0 for 3 cycles while inst=0x22 is presented -> inst and inst_pc held at 0x22/0x4, req_ready=0 for those 3 cycles, no request lost or duplicated, sequence resumes with 0x33.
- Fetch 0x2 and then 0x400 with DEPTH=256 -> two responses, both with inst_err=1 and inst=0x00000000. Then fetch 0x3FC -> inst=mem[255], inst_err=0.
- On the same edge, ld_we=1 with ld_addr=5 and ld_data=0xAA while fetching 0x14 (old mem[5]=0x55) -> response 0x55. A repeat fetch of 0x14 -> 0xAA.
- Assert rst for one cycle with 2 requests in flight (LATENCY=3) -> inst_valid=0 immediately and stays 0 until new requests are accepted after reset; no stale response appears.
- inst_ce toggling 1,0,1 with LATENCY=1 -> inst_valid pattern 1,0,1 delayed by one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch response record and NOP fill.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_resp_t;

endpackage : cpu_pkg

// File: rtl/inst_mem_array.sv
// Word memory with one synchronous read port and one synchronous write port.
// A read and write to the same word on one edge returns the old contents.
module inst_mem_array
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // Contents are deliberately left unreset; the loader fills them.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : inst_mem_array

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: accepts PC fetches, returns words after a
// fixed LATENCY through a stallable pipeline, flagging bad addresses.
module inst_mem_resp
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_ce,
    input  logic [31:0]     inst_addr,
    output logic            req_ready,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            inst_err,
    output logic [31:0]     inst_pc,
    input  logic            resp_ready,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [31:0]     ld_data
);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $fatal(1, "inst_mem_resp: LATENCY must be in 1..4");
        end
    endgenerate

    logic            stall;
    logic            accept;
    logic            req_err;
    logic [AW-1:0]   req_idx;
    logic [XLEN-1:0] rdata;

    logic            v0_q;
    logic            err0_q;
    logic [XLEN-1:0] pc0_q;

    fetch_resp_t     head;
    fetch_resp_t     tail;

    // Out-of-range is judged on the full word address, so no aliasing.
    assign req_err = (inst_addr[1:0] != 2'b00) ||
                     (inst_addr[31:2] >= 30'(DEPTH));
    assign req_idx = inst_addr[AW+1:2];

    assign stall     = tail.valid && !resp_ready;
    assign req_ready = !stall;
    assign accept    = inst_ce && req_ready;

    inst_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .re_i    (accept && !req_err),
        .raddr_i (req_idx),
        .rdata_o (rdata),
        .we_i    (ld_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data)
    );

    // Stage 1 control; its data lives in the array's read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q   <= 1'b0;
            err0_q <= 1'b0;
            pc0_q  <= '0;
        end else if (!stall) begin
            v0_q   <= inst_ce;
            err0_q <= req_err;
            pc0_q  <= inst_addr;
        end
    end

    always_comb begin
        head       = '0;
        head.valid = v0_q;
        head.err   = err0_q;
        head.pc    = pc0_q;
        head.data  = err0_q ? NOP_INSN : rdata;
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign tail = head;
        end else begin : g_latn
            fetch_resp_t pipe_q [LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY-1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (!stall) begin
                    pipe_q[0] <= head;
                    for (int i = 1; i < LATENCY-1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign tail = pipe_q[LATENCY-2];
        end
    endgenerate

    assign inst_valid = tail.valid;
    assign inst_err   = tail.err;
    assign inst_pc    = tail.pc;
    assign inst       = tail.data;

endmodule : inst_mem_resp

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp at LATENCY 1, 2 and 3 sharing one stimulus.
module tb_inst_mem_resp;

    logic        clk;
    logic        rst;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic        resp_ready;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic        rr1, rr2, rr3;
    logic [31:0] inst1, inst2, inst3;
    logic        v1, v2, v3;
    logic        e1, e2, e3;
    logic [31:0] pc1, pc2, pc3;

    int nvec = 0;
    int nerr = 0;

    inst_mem_resp #(.DEPTH(256), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr),
        .req_ready(rr1), .inst(inst1), .inst_valid(v1), .inst_err(e1),
        .inst_pc(pc1), .resp_ready(resp_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data));

    inst_mem_resp #(.DEPTH(256), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr),
        .req_ready(rr2), .inst(inst2), .inst_valid(v2), .inst_err(e2),
        .inst_pc(pc2), .resp_ready(resp_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data));

    inst_mem_resp #(.DEPTH(256), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .inst_ce(inst_ce), .inst_addr(inst_addr),
        .req_ready(rr3), .inst(inst3), .inst_valid(v3), .inst_err(e3),
        .inst_pc(pc3), .resp_ready(resp_ready), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full LATENCY=2 response check.
    task automatic chk2(input string tag, input logic [31:0] d, input logic [31:0] pc,
                        input logic err);
        chk({tag, ".valid"}, {31'd0, v2}, 32'd1);
        chk({tag, ".inst"},  inst2, d);
        chk({tag, ".pc"},    pc2, pc);
        chk({tag, ".err"},   {31'd0, e2}, {31'd0, err});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_ce = 1'b0; inst_addr = '0; resp_ready = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        step();

        chk("rst.valid2", {31'd0, v2}, 32'd0);
        chk("rst.err2",   {31'd0, e2}, 32'd0);
        chk("rst.inst2",  inst2, 32'd0);
        chk("rst.pc2",    pc2, 32'd0);
        chk("rst.rdy2",   {31'd0, rr2}, 32'd1);
        chk("rst.inst1",  inst1, 32'd0);
        chk("rst.valid3", {31'd0, v3}, 32'd0);
        rst = 1'b0;
        step();

        // Load memory
        ld_we = 1'b1;
        ld_addr = 8'd0;   ld_data = 32'h11; step();
        ld_addr = 8'd1;   ld_data = 32'h22; step();
        ld_addr = 8'd2;   ld_data = 32'h33; step();
        ld_addr = 8'd3;   ld_data = 32'h44; step();
        ld_addr = 8'd5;   ld_data = 32'h55; step();
        ld_addr = 8'd255; ld_data = 32'hDEADBEEF; step();
        ld_we = 1'b0;

        // Back-to-back stream, LATENCY=2
        inst_ce = 1'b1; inst_addr = 32'h0; step();
        chk("bb.lat_not_yet", {31'd0, v2}, 32'd0);
        inst_addr = 32'h4; step();
        chk2("bb0", 32'h11, 32'h0, 1'b0);
        inst_addr = 32'h8; step();
        chk2("bb1", 32'h22, 32'h4, 1'b0);
        inst_addr = 32'hC; step();
        chk2("bb2", 32'h33, 32'h8, 1'b0);
        inst_ce = 1'b0; step();
        chk2("bb3", 32'h44, 32'hC, 1'b0);
        step();
        chk("bb.bubble", {31'd0, v2}, 32'd0);

        // Stall for three cycles while 0x22 is presented
        inst_ce = 1'b1; inst_addr = 32'h0; step();
        inst_addr = 32'h4; step();
        chk2("st0", 32'h11, 32'h0, 1'b0);
        inst_addr = 32'h8; step();
        chk2("st1", 32'h22, 32'h4, 1'b0);
        inst_addr = 32'hC; resp_ready = 1'b0; #1;
        for (int c = 0; c < 3; c++) begin
            chk("st.hold.inst", inst2, 32'h22);
            chk("st.hold.pc",   pc2, 32'h4);
            chk("st.hold.rdy",  {31'd0, rr2}, 32'd0);
            chk("st.hold.v",    {31'd0, v2}, 32'd1);
            if (c < 2) step();
        end
        resp_ready = 1'b1; step();
        chk2("st2", 32'h33, 32'h8, 1'b0);
        inst_ce = 1'b0; step();
        chk2("st3", 32'h44, 32'hC, 1'b0);
        step();
        chk("st.drain", {31'd0, v2}, 32'd0);

        // Misaligned, out-of-range, last valid word
        inst_ce = 1'b1; inst_addr = 32'h2; step();
        inst_addr = 32'h400; step();
        chk2("err.mis", 32'h0, 32'h2, 1'b1);
        inst_addr = 32'h3FC; step();
        chk2("err.oor", 32'h0, 32'h400, 1'b1);
        inst_ce = 1'b0; step();
        chk2("err.last", 32'hDEADBEEF, 32'h3FC, 1'b0);
        step();

        // Loader/fetch collision: read-before-write
        ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'hAA;
        inst_ce = 1'b1; inst_addr = 32'h14; step();
        ld_we = 1'b0; step();
        chk2("rbw.old", 32'h55, 32'h14, 1'b0);
        inst_ce = 1'b0; step();
        chk2("rbw.new", 32'hAA, 32'h14, 1'b0);
        step(); step(); step();

        // Reset with two requests in flight, LATENCY=3
        inst_ce = 1'b1; inst_addr = 32'h0; step();
        inst_addr = 32'h4; step();
        chk("rs.pre.v3", {31'd0, v3}, 32'd0);
        inst_ce = 1'b0; rst = 1'b1; #1;
        chk("rs.async.v3", {31'd0, v3}, 32'd0);
        chk("rs.async.v2", {31'd0, v2}, 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rs.nostale.v3", {31'd0, v3}, 32'd0);
        end
        inst_ce = 1'b1; inst_addr = 32'h8; step();
        inst_ce = 1'b0; step();
        chk("rs.new.early", {31'd0, v3}, 32'd0);
        step();
        chk("rs.new.v3",   {31'd0, v3}, 32'd1);
        chk("rs.new.inst", inst3, 32'h33);
        chk("rs.new.pc",   pc3, 32'h8);
        step(); step(); step();

        // ce toggling 1,0,1 at LATENCY=1
        inst_ce = 1'b1; inst_addr = 32'h0; step();
        chk("tg.v1.a",    {31'd0, v1}, 32'd1);
        chk("tg.inst1.a", inst1, 32'h11);
        inst_ce = 1'b0; step();
        chk("tg.v1.b",    {31'd0, v1}, 32'd0);
        inst_ce = 1'b1; inst_addr = 32'h8; step();
        chk("tg.v1.c",    {31'd0, v1}, 32'd1);
        chk("tg.inst1.c", inst1, 32'h33);
        chk("tg.pc1.c",   pc1, 32'h8);
        inst_ce = 1'b0; step();
        chk("tg.v1.d",    {31'd0, v1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_inst_mem_resp
